// File: rtl/sdram_bram_responder.sv
// Block-RAM backed target for the sdram_req/sdram_ready/sdram_done handshake.
// One transaction at a time; done pulses LATENCY edges after acceptance, then waits for req release.
module sdram_bram_responder #(
   parameter int          ADDR_BITS = 14,
   parameter int          LATENCY   = 4,
   parameter logic [31:0] OOR_DATA  = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sdram_req,
   input  logic        sdram_write,
   input  logic [21:0] sdram_addr,
   input  logic [31:0] sdram_data_in,
   output logic [31:0] sdram_data_out,
   output logic        sdram_ready,
   output logic        sdram_done,
   output logic        err_oor,
   output logic        err_proto
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [21:0] addr_q, addr_d;
   logic [31:0] wdat_q, wdat_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic [31:0] dout_q, dout_d;
   logic        oor_q, oor_d;
   logic        proto_q, proto_d;
   logic        mem_we;
   logic        in_range;
   logic [31:0] rd_word;

   logic [31:0] mem [2**ADDR_BITS];

   assign in_range = (addr_q >> ADDR_BITS) == 22'd0;
   assign rd_word  = mem[addr_q[ADDR_BITS-1:0]];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      ready_d = 1'b0;
      done_d  = 1'b0;
      dout_d  = dout_q;
      oor_d   = oor_q;
      proto_d = proto_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sdram_req) begin
               wr_d    = sdram_write;
               addr_d  = sdram_addr;
               wdat_d  = sdram_data_in;
               cnt_d   = 4'(LATENCY - 1);
               state_d = BUSY;
            end else begin
               ready_d = 1'b1;
            end
         end
         BUSY: begin
            if (!sdram_req) proto_d = 1'b1;
            if (cnt_q == 4'd0) begin
               // Memory side effects happen on the edge that raises done.
               state_d = DONE;
               done_d  = 1'b1;
               if (!in_range) oor_d = 1'b1;
               if (wr_q) mem_we = in_range;
               else      dout_d = in_range ? rd_word : OOR_DATA;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            if (sdram_req) begin
               state_d = RELEASE;
            end else begin
               state_d = IDLE;
               ready_d = 1'b1;
            end
         end
         RELEASE: begin
            if (!sdram_req) begin
               state_d = IDLE;
               ready_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= 22'd0;
         wdat_q  <= 32'd0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         dout_q  <= 32'd0;
         oor_q   <= 1'b0;
         proto_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         dout_q  <= dout_d;
         oor_q   <= oor_d;
         proto_q <= proto_d;
      end
   end

   // RAM contents survive reset; only the pending commit is suppressed.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) mem[addr_q[ADDR_BITS-1:0]] <= wdat_q;
   end

   assign sdram_ready    = ready_q;
   assign sdram_done     = done_q;
   assign sdram_data_out = dout_q;
   assign err_oor        = oor_q;
   assign err_proto      = proto_q;

endmodule
